mem_arb_8x1024: RTL

- Two-requester round-robin arbiter and init sequencer for the single-port 8x1024 synchronous RAM (mem_8x1024).
- After reset, it optionally zero-fills the whole RAM.
- It then grants at most one requester access per cycle and returns read data with a fixed 1-cycle latency.
- Sits between the RAM instance and its two clients, e.g. the capture writer and the display reader.

---
 rtl/mem_arb_8x1024.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_arb_8x1024.sv
// rtl/mem_arb_8x1024.sv - two-requester round-robin arbiter and zero-fill sequencer for an 8x1024 RAM
module mem_arb_8x1024 #(
    parameter int DW      = 8,
    parameter int AW      = 10,
    parameter int INIT_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_d_i,
    input  logic [DW-1:0] mem_d_o,
    output logic          init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_last_b;      // 1 = B was granted last, so A wins the next tie
    logic          r_init_done;
    logic          r_a_rvalid;
    logic          r_b_rvalid;
    logic [DW-1:0] r_a_hold;
    logic [DW-1:0] r_b_hold;

    logic w_run;
    logic w_init;
    logic w_gnt_a;
    logic w_gnt_b;

    // Outputs are forced quiet while reset is held so an in-flight read never surfaces
    assign w_run   = !rst && (r_state == S_RUN);
    assign w_init  = !rst && (r_state == S_INIT);
    assign w_gnt_a = w_run && a_req && (!b_req || r_last_b);
    assign w_gnt_b = w_run && b_req && (!a_req || !r_last_b);

    assign a_gnt     = w_gnt_a;
    assign b_gnt     = w_gnt_b;
    assign a_rvalid  = !rst && r_a_rvalid;
    assign b_rvalid  = !rst && r_b_rvalid;
    assign a_rdata   = rst ? '0 : (r_a_rvalid ? mem_d_o : r_a_hold);
    assign b_rdata   = rst ? '0 : (r_b_rvalid ? mem_d_o : r_b_hold);
    assign init_done = rst ? (INIT_EN == 0) : r_init_done;

    // RAM port mux: zero-fill during init, otherwise the granted requester, otherwise idle zeros
    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_d_i  = '0;
        if (w_init) begin
            mem_wr   = 1'b1;
            mem_addr = r_cnt;
        end else if (w_gnt_a) begin
            mem_wr   = a_we;
            mem_addr = a_addr;
            mem_d_i  = a_wdata;
        end else if (w_gnt_b) begin
            mem_wr   = b_we;
            mem_addr = b_addr;
            mem_d_i  = b_wdata;
        end
    end

    // Sequencer state, round-robin history and read-return tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= (INIT_EN != 0) ? S_INIT : S_RUN;
            r_cnt       <= '0;
            r_last_b    <= 1'b1;
            r_init_done <= (INIT_EN == 0);
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_hold    <= '0;
            r_b_hold    <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {AW{1'b1}}) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (w_gnt_a) begin
                        r_last_b <= 1'b0;
                    end else if (w_gnt_b) begin
                        r_last_b <= 1'b1;
                    end
                end
            endcase
            r_a_rvalid <= w_gnt_a && !a_we;
            r_b_rvalid <= w_gnt_b && !b_we;
            if (r_a_rvalid) begin
                r_a_hold <= mem_d_o;
            end
            if (r_b_rvalid) begin
                r_b_hold <= mem_d_o;
            end
        end
    end

endmodule
